// File: rtl/alu_operand_driver_if.sv
// alu_operand_driver_if
//   Groups the command port, the operand/select drive into the combinational
//   logic unit, the unit result return, the result port and the busy flag.
//   Parameter: WIDTH - operand/result width in bits.
//   Modports:
//     slave  - the operand driver itself (accepts commands, drives the unit,
//              presents results).
//     master - the surrounding environment (issues commands, implements the
//              combinational unit, consumes results).
interface alu_operand_driver_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] unit_in1;
    logic [WIDTH-1:0] unit_in2;
    logic [1:0]       unit_sel;
    logic [WIDTH-1:0] unit_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, unit_out, res_ready,
        output cmd_ready, unit_in1, unit_in2, unit_sel, res_valid, res_data, res_zero, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, unit_out, res_ready,
        input  cmd_ready, unit_in1, unit_in2, unit_sel, res_valid, res_data, res_zero, busy
    );
endinterface

// File: rtl/alu_operand_driver.sv
// alu_operand_driver
//   Sequential initiator for the combinational AND/OR/XOR/NOR unit. Takes one
//   command at a time, holds operands/select on the unit for SETTLE_CYCLES,
//   then registers the unit output and its zero flag onto a valid/ready
//   result port.
//   Parameters: WIDTH (data width), SETTLE_CYCLES (1..15, drive-to-sample).
//   Ports: clk, rst_n (async active-low), bus (alu_operand_driver_if.slave).
module alu_operand_driver #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_operand_driver_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StResult} state_e;

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_valid_q, res_valid_d;
    logic             cmd_ready;

    // rst_n gates ready directly so nothing can be accepted during reset.
    assign cmd_ready = (state_q == StIdle) && rst_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        sel_d       = sel_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready) begin
                    in1_d   = bus.cmd_a;
                    in2_d   = bus.cmd_b;
                    sel_d   = bus.cmd_op;
                    cnt_d   = SettleInit;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                // Last settle cycle: the unit output has been stable long enough.
                if (cnt_q == 4'd1) begin
                    res_data_d  = bus.unit_out;
                    res_zero_d  = ~|bus.unit_out;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end
            end
            StResult: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            in1_q       <= '0;
            in2_q       <= '0;
            sel_q       <= 2'b00;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            sel_q       <= sel_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.unit_in1  = in1_q;
    assign bus.unit_in2  = in2_q;
    assign bus.unit_sel  = sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
